// File: rtl/adder_pipe.sv
// Two-stage ready/valid adder: forms a+b, a+cb, b+cb and a+b+cb with per-sum
// overflow flags, optional clamping, and a saturating overflow-event counter.
module adder_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cb,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_ab,
    output logic [WIDTH-1:0] sum_ac,
    output logic [WIDTH-1:0] sum_bc,
    output logic [WIDTH-1:0] sum_abc,
    output logic [3:0]       ovf,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic ovf_of(input logic [WIDTH+1:0] exact);
        return |exact[WIDTH+1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] clamp_sum(input logic [WIDTH+1:0] exact,
                                                   input logic             sat);
        if (sat && ovf_of(exact)) return '1;
        return exact[WIDTH-1:0];
    endfunction

    logic             vld_p1;
    logic             sat_p1;
    logic [WIDTH-1:0] cb_p1;
    logic [WIDTH:0]   sab_p1;
    logic [WIDTH:0]   sac_p1;
    logic [WIDTH:0]   sbc_p1;
    logic             vld_p2;

    logic             s1_load;
    logic             s2_load;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH+1:0] ab_x;
    logic [WIDTH+1:0] ac_x;
    logic [WIDTH+1:0] bc_x;
    logic [WIDTH+1:0] abc_x;

    assign out_valid = vld_p2;
    assign s2_load   = !vld_p2 || out_ready;
    assign s1_load   = !vld_p1 || s2_load;
    assign in_ready  = rst_n && (!vld_p1 || !vld_p2 || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = vld_p2 && out_ready;

    assign ab_x  = {1'b0, sab_p1};
    assign ac_x  = {1'b0, sac_p1};
    assign bc_x  = {1'b0, sbc_p1};
    assign abc_x = {1'b0, sab_p1} + {2'b00, cb_p1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_load) vld_p1 <= in_xfer;
            if (s2_load) vld_p2 <= vld_p1;
        end
    end

    // Stage 1: pairwise sums at WIDTH+1, plus what stage 2 still needs
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            cb_p1  <= cb;
            sat_p1 <= sat_en;
            sab_p1 <= {1'b0, a} + {1'b0, b};
            sac_p1 <= {1'b0, a} + {1'b0, cb};
            sbc_p1 <= {1'b0, b} + {1'b0, cb};
        end
    end

    // Stage 2: triple sum, overflow flags and clamping; held while stalled or idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_ab  <= '0;
            sum_ac  <= '0;
            sum_bc  <= '0;
            sum_abc <= '0;
            ovf     <= '0;
        end else if (vld_p1 && s2_load) begin
            sum_ab  <= clamp_sum(ab_x, sat_p1);
            sum_ac  <= clamp_sum(ac_x, sat_p1);
            sum_bc  <= clamp_sum(bc_x, sat_p1);
            sum_abc <= clamp_sum(abc_x, sat_p1);
            ovf     <= {ovf_of(abc_x), ovf_of(bc_x), ovf_of(ac_x), ovf_of(ab_x)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || ovf_clr) begin
            ovf_cnt <= '0;
        end else if (out_xfer && (ovf != 4'b0000) && (ovf_cnt != CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: table vectors, backpressure, counter saturation/clear
// and mid-flight reset, all scored against an integer reference model.
module tb_adder_pipe;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int NV = 10;

    typedef struct packed {
        logic [W-1:0] ab;
        logic [W-1:0] ac;
        logic [W-1:0] bc;
        logic [W-1:0] abc;
        logic [3:0]   ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] cb;
        logic         s;
        res_t         exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, cb;
    logic          sat_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum_ab, sum_ac, sum_bc, sum_abc;
    logic [3:0]    ovf;
    logic [CW-1:0] ovf_cnt;
    logic          ovf_clr;
    res_t          got;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   m_cnt  = 0;
    res_t q[$];
    res_t prev;
    logic have_prev = 1'b0;
    vec_t tbl[NV];

    adder_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cb(cb), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_ab(sum_ab), .sum_ac(sum_ac), .sum_bc(sum_bc), .sum_abc(sum_abc),
        .ovf(ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    assign got = {sum_ab, sum_ac, sum_bc, sum_abc, ovf};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out or unexpected event", name);
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] z, input logic s);
        int   e[4];
        res_t r;
        logic [W-1:0] v[4];
        e[0] = int'(x) + int'(y);
        e[1] = int'(x) + int'(z);
        e[2] = int'(y) + int'(z);
        e[3] = int'(x) + int'(y) + int'(z);
        for (int i = 0; i < 4; i++) begin
            r.ovf[i] = (e[i] > 255);
            v[i] = (r.ovf[i] && s) ? 8'd255 : 8'(e[i] % 256);
        end
        r.ab = v[0]; r.ac = v[1]; r.bc = v[2]; r.abc = v[3];
        return r;
    endfunction

    function automatic vec_t mk(input int x, input int y, input int z, input logic s,
                                input int eab, input int eac, input int ebc, input int eabc,
                                input logic [3:0] eovf);
        vec_t v;
        v.a = 8'(x); v.b = 8'(y); v.cb = 8'(z); v.s = s;
        v.exp = {8'(eab), 8'(eac), 8'(ebc), 8'(eabc), eovf};
        return v;
    endfunction

    // Scoreboard: push at accepted input, pop and compare at output transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            have_prev = 1'b0;
        end else begin
            chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
            if (have_prev) chk("stall_hold", {out_valid, got}, {1'b1, prev});
            have_prev = out_valid && !out_ready;
            prev = got;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("sb_unexpected_output");
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("sb_result", got, e);
                    n_out++;
                    if (e.ovf != 4'b0000 && m_cnt != (1 << CW) - 1) m_cnt++;
                end
            end
            if (ovf_clr) m_cnt = 0;
            if (in_valid && in_ready) q.push_back(model(a, b, cb, sat_en));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input int x, input int y, input int z, input logic s);
        logic acc;
        int   guard;
        guard = 0;
        a = 8'(x); b = 8'(y); cb = 8'(z); sat_en = s; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) fail_now("send_accept");
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) fail_now("drain");
    endtask

    initial begin
        int k;
        int exp_cnt;
        int n0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cb = '0; sat_en = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;

        tbl[0] = mk(3,   5,   7,   1'b0,   8,  10,  12,  15, 4'b0000);
        tbl[1] = mk(200, 100, 0,   1'b0,  44, 200, 100,  44, 4'b1001);
        tbl[2] = mk(200, 100, 0,   1'b1, 255, 200, 100, 255, 4'b1001);
        tbl[3] = mk(255, 255, 255, 1'b0, 254, 254, 254, 253, 4'b1111);
        tbl[4] = mk(255, 255, 255, 1'b1, 255, 255, 255, 255, 4'b1111);
        tbl[5] = mk(0,   0,   0,   1'b0,   0,   0,   0,   0, 4'b0000);
        tbl[6] = mk(128, 127, 1,   1'b0, 255, 129, 128,   0, 4'b1000);
        tbl[7] = mk(128, 127, 1,   1'b1, 255, 129, 128, 255, 4'b1000);
        tbl[8] = mk(1,   255, 0,   1'b1, 255,   1, 255, 255, 4'b1001);
        tbl[9] = mk(100, 50,  206, 1'b0, 150,  50,   0, 100, 4'b1110);

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", got, 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cb, tbl[i].s);
            wait_out(k);
            chk("latency", 64'(k), 64'd2);
            chk($sformatf("vec%0d", i), got, tbl[i].exp);
            if (tbl[i].exp.ovf != 4'b0000) exp_cnt++;
            @(negedge clk);
            chk($sformatf("vec%0d_ovf_cnt", i), 64'(ovf_cnt), 64'(exp_cnt));
            @(posedge clk); #1;
        end

        // Reset with two sets held in the pipeline
        out_ready = 1'b0;
        send(10, 20, 30, 1'b0);
        send(40, 50, 60, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_outputs", got, 64'd0);
        chk("midrst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Ten back-to-back sets with a five-cycle output stall
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i, 250, i * 20, 1'(i % 2));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", 64'(n_out - n0), 64'd10);
        @(posedge clk); #1;

        // Counter saturation, then clear against a concurrent overflowing transfer
        repeat (20) send(255, 255, 255, 1'b0);
        drain();
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_saturated", 64'(ovf_cnt), 64'd15);
        @(posedge clk); #1 out_ready = 1'b0;
        send(200, 100, 0, 1'b1);
        wait_out(k);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_priority", 64'(ovf_cnt), 64'd0);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
